ext_ram_sched: RTL and testbench
================================

# ext_ram_sched

Four-way cycle scheduler that shares the single external NoBL/ZBT SRAM port between the two buffered channels (channel 0 and channel 1). Each channel has a write side and a read side:
- the write side is fed from its 36-to-18 ingress FIFO;
- the read side drains into its 18-to-36 egress FIFO.

The block owns the per-channel ring pointers and occupancy, issues one SRAM command per cycle, and tags read returns back to their channel. It sits in the ext_clk domain between the ingress/egress FIFOs and the SRAM pin-driver pipeline.

## Interface
Parameters:
- RAM_DEPTH, 19, SRAM address width; each channel owns half the array, 2^(RAM_DEPTH-1) words.
- BURST, 8, maximum consecutive grants to one slot before forced rotation (1..255).
- READ_LAT, 4, cycles from ram_cmd_valid of a read to its data at the pin-driver output (>=1).

Ports:
- clk  in  1  ext_clk domain clock.
- rst  in  1  synchronous, active-low reset.
- wr_valid  in  2  per channel, ingress FIFO not empty (FWFT word present).
- rd_ready  in  2  per channel, egress FIFO not almost-full.
- wr_ack  out  2  one-hot; pops the ingress FIFO this cycle.
- rd_ack  out  2  one-hot; a read for that channel was issued this cycle.
- ram_cmd_valid  out  1  registered SRAM command strobe.
- ram_cmd_we  out  1  1 = write, 0 = read.
- ram_cmd_addr  out  RAM_DEPTH  channel bit in the MSB, ring pointer below it.
- ram_cmd_ch  out  1  channel of the command; steers write data.
- rd_data_valid  out  2  one-hot; the SRAM read word for that channel is valid now.
- occupancy0, occupancy1  out  RAM_DEPTH each  words held per channel.
- debug  out  32  statistics (see Configuration).

## Operation
- Slots, in fixed rotation order: W0=0, R0=1, W1=2, R1=3.
- Eligibility:
  - Wk is eligible when wr_valid[k] is high and occupancy k is below 2^(RAM_DEPTH-1).
  - Rk is eligible when rd_ready[k] is high and occupancy k is above 0.
- Owner register (reset value W0) and burst_cnt.
- Each cycle the owner keeps the grant while it is eligible and burst_cnt is below BURST.
- Otherwise the grant goes to the first eligible slot searching owner+1, owner+2, owner+3, owner (wrapping). A change of owner reloads burst_cnt to 1.
- If the owner's burst is exhausted and no other slot is eligible, the owner keeps the grant and burst_cnt reloads to 1.
- No eligible slot: no ack; owner and burst_cnt hold.
- At most one grant per cycle, so wr_ack and rd_ack together are zero-or-one-hot.
- Write grant for channel k:
  - wr_ack[k]=1;
  - command has we=1 and addr={k, wptr_k};
  - wptr_k increments;
  - occupancy k increments.
- Read grant for channel k:
  - rd_ack[k]=1;
  - command has we=0 and addr={k, rptr_k};
  - rptr_k increments;
  - occupancy k decrements.
- Pointers are RAM_DEPTH-1 bits and wrap naturally modulo the half-array. Occupancy is RAM_DEPTH bits wide so that full is representable.
- Occupancy counts issued commands rather than completed ones. Because only one grant is issued per cycle, a channel never sees +1 and -1 in the same cycle.
- Read return uses a READ_LAT-deep shift register of {valid, ch} that drives rd_data_valid.

## Timing
- wr_ack and rd_ack are combinational from registered state plus wr_valid/rd_ready, and are asserted in grant cycle N.
- ram_cmd_* is registered and valid in cycle N+1.
- rd_data_valid is asserted in cycle N+1+READ_LAT.
- Occupancy and pointers update at the clk edge ending cycle N.
- Reset values:
  - all outputs 0;
  - pointers, occupancy and burst_cnt 0;
  - owner W0;
  - read-tag pipeline cleared.
- Reset asserted mid-operation discards in-flight reads: no rd_data_valid in the cycles after reset, even if a read was outstanding.
- Full channel: Wk is ineligible. Empty channel: Rk is ineligible. The other channel is unaffected.
- A read for a word written in the same grant burst is legal; the SRAM pipeline preserves ordering.

## Configuration
- EXT_RAM_SCHED_STATS_EN defined:
  - debug[15:0] is a saturating count of cycles with at least one eligible slot that went ungranted to channel 0; debug[31:16] is the same for channel 1.
  - An ungranted-but-eligible cycle is one where another slot won.
  - Both counters clear on reset.
- Macro undefined: debug is tied to 0 and no counters are synthesised.

## Structure
- Package ext_ram_sched_pkg holds:
  - slot encoding constants SLOT_W0, SLOT_R0, SLOT_W1, SLOT_R1;
  - slot width 2;
  - the rotation-next function.
- Sub-module ext_ram_rr_pick: a combinational 4-input rotating priority picker. Inputs are the eligible vector and owner; outputs are the chosen slot and a none flag.

## Test plan
- Reset, then wr_valid=2'b01 held for 3 cycles: wr_ack[0] high for 3 cycles; addresses 0x00000, 0x00001, 0x00002 on ram_cmd one cycle later; occupancy0=3.
- Channel 0 holds 4 words and rd_ready=2'b01: reads at addr 0..3; rd_data_valid[0] arrives exactly READ_LAT+1 cycles after each rd_ack; occupancy0 returns to 0 and reads then stop.
- All four slots eligible continuously with BURST=8: grants run 8×W0, 8×R0, 8×W1, 8×R1 and repeat.
- Fill channel 1 to 2^18 words: wr_ack[1] stops, channel 0 traffic continues, and ram_cmd_addr MSB is 1 for all channel-1 commands. Then read once and write once: wptr1 wraps to 0.
- Drop rst low for 1 cycle with 2 reads in flight: no rd_data_valid afterward; all outputs and occupancies read 0.
- With EXT_RAM_SCHED_STATS_EN, W0 and W1 contend for 16 cycles with BURST=8: debug[15:0]=8 and debug[31:16]=8.

Source files
------------

// File: rtl/ext_ram_sched_pkg.sv
// Shared slot encoding and rotation helper for the external SRAM cycle scheduler.
package ext_ram_sched_pkg;

  localparam int unsigned SLOT_W = 2;

  typedef enum logic [SLOT_W-1:0] {
    SLOT_W0 = 2'd0,
    SLOT_R0 = 2'd1,
    SLOT_W1 = 2'd2,
    SLOT_R1 = 2'd3
  } slot_e;

  function automatic slot_e slot_next(input slot_e s);
    return slot_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/ext_ram_rr_pick.sv
// Rotating priority picker: first eligible slot searching owner+1 .. owner+3, owner.
module ext_ram_rr_pick
  import ext_ram_sched_pkg::*;
(
  input  logic [3:0] elig_i,
  input  slot_e      owner_i,
  output slot_e      pick_o,
  output logic       none_o
);

  always_comb begin
    slot_e cand;
    cand   = owner_i;
    pick_o = owner_i;
    none_o = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = slot_next(cand);
      if (none_o && elig_i[cand]) begin
        pick_o = cand;
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ext_ram_sched.sv
// Four-slot SRAM cycle scheduler for two buffered channels (ring pointers, occupancy, read tags).
// Optional per-channel starvation statistics on debug when EXT_RAM_SCHED_STATS_EN is defined.
module ext_ram_sched
  import ext_ram_sched_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 19,
  parameter int unsigned BURST     = 8,
  parameter int unsigned READ_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           wr_valid,
  input  logic [1:0]           rd_ready,
  output logic [1:0]           wr_ack,
  output logic [1:0]           rd_ack,
  output logic                 ram_cmd_valid,
  output logic                 ram_cmd_we,
  output logic [RAM_DEPTH-1:0] ram_cmd_addr,
  output logic                 ram_cmd_ch,
  output logic [1:0]           rd_data_valid,
  output logic [RAM_DEPTH-1:0] occupancy0,
  output logic [RAM_DEPTH-1:0] occupancy1,
  output logic [31:0]          debug
);

  localparam int unsigned PW = RAM_DEPTH - 1;
  localparam logic [RAM_DEPTH-1:0] FULL = {1'b1, {PW{1'b0}}};
  localparam logic [7:0] BURST_L = 8'(BURST);

  slot_e owner_q, owner_d, pick, gnt_slot;
  logic [7:0] burst_q, burst_d;
  logic       pick_none, gnt_valid, gnt_ch, gnt_we;
  logic [3:0] elig;

  logic [PW-1:0]        wptr_q [2];
  logic [PW-1:0]        wptr_d [2];
  logic [PW-1:0]        rptr_q [2];
  logic [PW-1:0]        rptr_d [2];
  logic [RAM_DEPTH-1:0] occ_q  [2];
  logic [RAM_DEPTH-1:0] occ_d  [2];

  logic                 cmd_valid_d, cmd_we_d, cmd_ch_d;
  logic [RAM_DEPTH-1:0] cmd_addr_d;
  logic [1:0]           tag_q [READ_LAT];

  always_comb begin
    elig          = '0;
    elig[SLOT_W0] = wr_valid[0] && (occ_q[0] < FULL);
    elig[SLOT_R0] = rd_ready[0] && (occ_q[0] != '0);
    elig[SLOT_W1] = wr_valid[1] && (occ_q[1] < FULL);
    elig[SLOT_R1] = rd_ready[1] && (occ_q[1] != '0);
  end

  ext_ram_rr_pick u_pick (
    .elig_i (elig),
    .owner_i(owner_q),
    .pick_o (pick),
    .none_o (pick_none)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= SLOT_W0;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // An exhausted owner with no competitor is re-picked by the search and so reloads to 1.
  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    gnt_valid = 1'b0;
    gnt_slot  = owner_q;
    if (elig[owner_q] && (burst_q < BURST_L)) begin
      gnt_valid = 1'b1;
      burst_d   = burst_q + 8'd1;
    end else if (!pick_none) begin
      gnt_valid = 1'b1;
      gnt_slot  = pick;
      owner_d   = pick;
      burst_d   = 8'd1;
    end
  end

  always_comb begin
    wr_ack = '0;
    rd_ack = '0;
    gnt_ch = (gnt_slot == SLOT_W1) || (gnt_slot == SLOT_R1);
    gnt_we = (gnt_slot == SLOT_W0) || (gnt_slot == SLOT_W1);
    if (gnt_valid) begin
      if (gnt_we) wr_ack[gnt_ch] = 1'b1;
      else        rd_ack[gnt_ch] = 1'b1;
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    cmd_valid_d = gnt_valid;
    cmd_we_d    = 1'b0;
    cmd_ch_d    = 1'b0;
    cmd_addr_d  = '0;
    if (gnt_valid) begin
      cmd_we_d = gnt_we;
      cmd_ch_d = gnt_ch;
      if (gnt_we) begin
        cmd_addr_d            = {gnt_ch, wptr_q[gnt_ch]};
        wptr_d[gnt_ch]        = wptr_q[gnt_ch] + PW'(1);
        occ_d[gnt_ch]         = occ_q[gnt_ch] + RAM_DEPTH'(1);
      end else begin
        cmd_addr_d            = {gnt_ch, rptr_q[gnt_ch]};
        rptr_d[gnt_ch]        = rptr_q[gnt_ch] + PW'(1);
        occ_d[gnt_ch]         = occ_q[gnt_ch] - RAM_DEPTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q        <= '{default: '0};
      rptr_q        <= '{default: '0};
      occ_q         <= '{default: '0};
      ram_cmd_valid <= 1'b0;
      ram_cmd_we    <= 1'b0;
      ram_cmd_ch    <= 1'b0;
      ram_cmd_addr  <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      occ_q         <= occ_d;
      ram_cmd_valid <= cmd_valid_d;
      ram_cmd_we    <= cmd_we_d;
      ram_cmd_ch    <= cmd_ch_d;
      ram_cmd_addr  <= cmd_addr_d;
      tag_q[0]      <= {ram_cmd_valid & ~ram_cmd_we, ram_cmd_ch};
      for (int unsigned i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rd_data_valid = {tag_q[READ_LAT-1][1] &  tag_q[READ_LAT-1][0],
                          tag_q[READ_LAT-1][1] & ~tag_q[READ_LAT-1][0]};
  assign occupancy0    = occ_q[0];
  assign occupancy1    = occ_q[1];

`ifdef EXT_RAM_SCHED_STATS_EN
  logic [15:0] miss_q [2];
  logic [1:0]  miss_hit;

  always_comb begin
    miss_hit[0] = gnt_valid && ((elig[SLOT_W0] && (gnt_slot != SLOT_W0)) ||
                                (elig[SLOT_R0] && (gnt_slot != SLOT_R0)));
    miss_hit[1] = gnt_valid && ((elig[SLOT_W1] && (gnt_slot != SLOT_W1)) ||
                                (elig[SLOT_R1] && (gnt_slot != SLOT_R1)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_q <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < 2; k++)
        if (miss_hit[k] && (miss_q[k] != '1)) miss_q[k] <= miss_q[k] + 16'd1;
    end
  end

  assign debug = {miss_q[1], miss_q[0]};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_ext_ram_sched.sv
// Scoreboard bench for ext_ram_sched: a reference scheduler model predicts grants, commands and read returns.
module tb_ext_ram_sched;

  localparam int unsigned RD   = 5;
  localparam int unsigned BU   = 8;
  localparam int unsigned RL   = 4;
  localparam int          HALF = 1 << (RD - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    wr_valid = '0, rd_ready = '0;
  logic [1:0]    wr_ack, rd_ack, rd_data_valid;
  logic          ram_cmd_valid, ram_cmd_we, ram_cmd_ch;
  logic [RD-1:0] ram_cmd_addr, occupancy0, occupancy1;
  logic [31:0]   debug;

  ext_ram_sched #(.RAM_DEPTH(RD), .BURST(BU), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .rd_ready(rd_ready),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .ram_cmd_valid(ram_cmd_valid),
    .ram_cmd_we(ram_cmd_we), .ram_cmd_addr(ram_cmd_addr), .ram_cmd_ch(ram_cmd_ch),
    .rd_data_valid(rd_data_valid), .occupancy0(occupancy0), .occupancy1(occupancy1),
    .debug(debug)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned due; logic we; logic [RD-1:0] addr; logic ch; } cmd_t;
  typedef struct { int unsigned due; logic [1:0] vec; } ret_t;
  cmd_t cmd_q[$];
  ret_t ret_q[$];
  cmd_t ce;
  logic [1:0] rexp;

  int pass_cnt = 0, chk_cnt = 0;
  bit mon_en = 1'b0;

  int m_owner, m_burst;
  int m_occ[2], m_wp[2], m_rp[2];

  task automatic model_reset();
    m_owner = 0; m_burst = 0;
    for (int k = 0; k < 2; k++) begin m_occ[k] = 0; m_wp[k] = 0; m_rp[k] = 0; end
  endtask

  // One clock cycle: drive inputs, return observed and predicted acks, advance the model.
  task automatic tick(input logic [1:0] wv, input logic [1:0] rr, input logic rstn,
                      output logic [1:0] gw, output logic [1:0] gr,
                      output logic [1:0] ew, output logic [1:0] er);
    logic [3:0] el;
    int s, ch;
    @(posedge clk); #1;
    wr_valid = wv; rd_ready = rr; rst = rstn;
    #1;
    gw = wr_ack; gr = rd_ack; ew = '0; er = '0;
    if (!rstn) begin
      model_reset();
      while (ret_q.size() > 0 && ret_q[$].due > cyc) void'(ret_q.pop_back());
      return;
    end
    el[0] = wv[0] && (m_occ[0] < HALF);
    el[1] = rr[0] && (m_occ[0] > 0);
    el[2] = wv[1] && (m_occ[1] < HALF);
    el[3] = rr[1] && (m_occ[1] > 0);
    s = -1;
    if (el[m_owner] && m_burst < BU) begin
      s = m_owner; m_burst++;
    end else begin
      for (int i = 1; i <= 4; i++) if (s < 0 && el[(m_owner + i) % 4]) s = (m_owner + i) % 4;
      if (s >= 0) begin m_owner = s; m_burst = 1; end
    end
    if (s >= 0) begin
      ch = s / 2;
      if (s % 2 == 0) begin
        ew[ch] = 1'b1;
        cmd_q.push_back('{cyc + 1, 1'b1, RD'(ch * HALF + m_wp[ch]), ch == 1});
        m_wp[ch] = (m_wp[ch] + 1) % HALF; m_occ[ch]++;
      end else begin
        er[ch] = 1'b1;
        cmd_q.push_back('{cyc + 1, 1'b0, RD'(ch * HALF + m_rp[ch]), ch == 1});
        ret_q.push_back('{cyc + 1 + RL, (ch == 1) ? 2'b10 : 2'b01});
        m_rp[ch] = (m_rp[ch] + 1) % HALF; m_occ[ch]--;
      end
    end
  endtask

  task automatic idle(input int n);
    logic [1:0] gw, gr, ew, er;
    for (int i = 0; i < n; i++) tick(2'b00, 2'b00, 1'b1, gw, gr, ew, er);
  endtask

  task automatic do_reset(input int n);
    logic [1:0] gw, gr, ew, er;
    for (int i = 0; i < n; i++) tick(2'b00, 2'b00, 1'b0, gw, gr, ew, er);
  endtask

  // Scoreboard consumer: registered command and read-return outputs against queued expectations.
  always @(negedge clk) if (mon_en) begin
    chk_cnt++;
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      ce = cmd_q.pop_front();
      if ({ram_cmd_valid, ram_cmd_we, ram_cmd_addr, ram_cmd_ch} !== {1'b1, ce.we, ce.addr, ce.ch})
        $display("FAIL cmd cyc=%0d got v=%b we=%b addr=%0h ch=%b exp we=%b addr=%0h ch=%b",
                 cyc, ram_cmd_valid, ram_cmd_we, ram_cmd_addr, ram_cmd_ch, ce.we, ce.addr, ce.ch);
      else pass_cnt++;
    end else if (ram_cmd_valid !== 1'b0) $display("FAIL cmd_idle cyc=%0d got valid=%b exp 0", cyc, ram_cmd_valid);
    else pass_cnt++;
    rexp = 2'b00;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) rexp = ret_q.pop_front().vec;
    chk_cnt++;
    if (rd_data_valid !== rexp)
      $display("FAIL rd_data_valid cyc=%0d got=%b exp=%b", cyc, rd_data_valid, rexp);
    else pass_cnt++;
  end

  task automatic test_reset();
    do_reset(2);
    chk_cnt++; if ({wr_ack, rd_ack} !== 4'b0) $display("FAIL reset_ack got=%b exp=0", {wr_ack, rd_ack}); else pass_cnt++;
    chk_cnt++; if ({ram_cmd_valid, ram_cmd_we, ram_cmd_ch, ram_cmd_addr} !== '0)
      $display("FAIL reset_cmd got=%0h exp=0", {ram_cmd_valid, ram_cmd_we, ram_cmd_ch, ram_cmd_addr}); else pass_cnt++;
    chk_cnt++; if (rd_data_valid !== 2'b00) $display("FAIL reset_rdv got=%b exp=0", rd_data_valid); else pass_cnt++;
    chk_cnt++; if ({occupancy0, occupancy1} !== '0) $display("FAIL reset_occ got=%0h/%0h exp=0", occupancy0, occupancy1); else pass_cnt++;
    chk_cnt++; if (debug !== 32'h0) $display("FAIL reset_debug got=%0h exp=0", debug); else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_write_burst();
    logic [1:0] gw, gr, ew, er;
    for (int i = 0; i < 3; i++) begin
      tick(2'b01, 2'b00, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== 4'b0100) $display("FAIL wr_burst_ack i=%0d got=%b exp=0100", i, {gw, gr}); else pass_cnt++;
    end
    idle(2);
    chk_cnt++; if (occupancy0 !== RD'(3)) $display("FAIL wr_burst_occ0 got=%0d exp=3", occupancy0); else pass_cnt++;
  endtask

  task automatic test_read_drain();
    logic [1:0] gw, gr, ew, er;
    tick(2'b01, 2'b00, 1'b1, gw, gr, ew, er);
    chk_cnt++; if (occupancy0 !== RD'(4) && occupancy0 !== RD'(3)) $display("FAIL drain_fill got=%0d exp=4", occupancy0); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick(2'b00, 2'b01, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== ((i < 4) ? 4'b0001 : 4'b0000))
        $display("FAIL drain_ack i=%0d got=%b exp=%b", i, {gw, gr}, (i < 4) ? 4'b0001 : 4'b0000); else pass_cnt++;
    end
    idle(RL + 2);
    chk_cnt++; if (occupancy0 !== '0) $display("FAIL drain_occ0 got=%0d exp=0", occupancy0); else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [1:0] gw, gr, ew, er;
    logic [3:0] pat;
    do_reset(1);
    for (int i = 0; i < 64; i++) begin
      tick(2'b11, 2'b11, 1'b1, gw, gr, ew, er);
      case ((i / 8) % 4)
        0: pat = 4'b0100;
        1: pat = 4'b0001;
        2: pat = 4'b1000;
        default: pat = 4'b0010;
      endcase
      chk_cnt++; if ({gw, gr} !== pat) $display("FAIL rotation i=%0d got=%b exp=%b", i, {gw, gr}, pat); else pass_cnt++;
    end
    idle(RL + 2);
  endtask

  task automatic test_full_ch1();
    logic [1:0] gw, gr, ew, er;
    do_reset(1);
    for (int i = 0; i < HALF + 3; i++) begin
      tick(2'b10, 2'b00, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== ((i < HALF) ? 4'b1000 : 4'b0000))
        $display("FAIL fill1_ack i=%0d got=%b", i, {gw, gr}); else pass_cnt++;
    end
    chk_cnt++; if (occupancy1 !== RD'(HALF)) $display("FAIL fill1_occ got=%0d exp=%0d", occupancy1, HALF); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(2'b11, 2'b00, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== 4'b0100) $display("FAIL full_ch0_ack i=%0d got=%b exp=0100", i, {gw, gr}); else pass_cnt++;
    end
    tick(2'b00, 2'b10, 1'b1, gw, gr, ew, er);
    chk_cnt++; if ({gw, gr} !== 4'b0010) $display("FAIL full_rd1_ack got=%b exp=0010", {gw, gr}); else pass_cnt++;
    tick(2'b10, 2'b00, 1'b1, gw, gr, ew, er);
    chk_cnt++; if ({gw, gr} !== 4'b1000) $display("FAIL wrap_wr1_ack got=%b exp=1000", {gw, gr}); else pass_cnt++;
    idle(1);
    chk_cnt++; if ({ram_cmd_valid, ram_cmd_we, ram_cmd_addr} !== {2'b11, RD'(HALF)})
      $display("FAIL wptr1_wrap got=%b%b_%0h exp=11_%0h", ram_cmd_valid, ram_cmd_we, ram_cmd_addr, HALF); else pass_cnt++;
    chk_cnt++; if (occupancy1 !== RD'(HALF)) $display("FAIL wrap_occ1 got=%0d exp=%0d", occupancy1, HALF); else pass_cnt++;
    idle(RL + 2);
  endtask

  task automatic test_mid_reset();
    logic [1:0] gw, gr, ew, er;
    do_reset(1);
    tick(2'b01, 2'b00, 1'b1, gw, gr, ew, er);
    tick(2'b01, 2'b00, 1'b1, gw, gr, ew, er);
    for (int i = 0; i < 2; i++) begin
      tick(2'b00, 2'b01, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== 4'b0001) $display("FAIL inflight_rd_ack i=%0d got=%b exp=0001", i, {gw, gr}); else pass_cnt++;
    end
    idle(1);
    do_reset(1);
    for (int i = 0; i < int'(RL) + 4; i++) begin
      idle(1);
      chk_cnt++; if (rd_data_valid !== 2'b00) $display("FAIL post_reset_rdv i=%0d got=%b exp=00", i, rd_data_valid); else pass_cnt++;
    end
    chk_cnt++; if ({wr_ack, rd_ack, ram_cmd_valid, ram_cmd_we, ram_cmd_ch, ram_cmd_addr, occupancy0, occupancy1} !== '0)
      $display("FAIL post_reset_outputs got=%0h exp=0",
               {wr_ack, rd_ack, ram_cmd_valid, ram_cmd_we, ram_cmd_ch, ram_cmd_addr, occupancy0, occupancy1}); else pass_cnt++;
  endtask

  task automatic test_stats();
    logic [1:0] gw, gr, ew, er;
    logic [31:0] exp_dbg;
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      tick(2'b11, 2'b00, 1'b1, gw, gr, ew, er);
      chk_cnt++; if ({gw, gr} !== ((i < 8) ? 4'b0100 : 4'b1000)) $display("FAIL contend_ack i=%0d got=%b", i, {gw, gr}); else pass_cnt++;
    end
    idle(1);
`ifdef EXT_RAM_SCHED_STATS_EN
    exp_dbg = {16'd8, 16'd8};
`else
    exp_dbg = 32'h0;
`endif
    chk_cnt++; if (debug !== exp_dbg) $display("FAIL stats_debug got=%0h exp=%0h", debug, exp_dbg); else pass_cnt++;
    idle(RL + 2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_burst();
    test_read_drain();
    test_rotation();
    test_full_ch1();
    test_mid_reset();
    test_stats();
    chk_cnt++; if (cmd_q.size() != 0 || ret_q.size() != 0)
      $display("FAIL scoreboard_drain got cmd=%0d ret=%0d exp 0/0", cmd_q.size(), ret_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
